// File: rtl/hazard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_pkg : shared types, defaults and helpers for hazard_ctrl_unit     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } hazard_state_e;

    localparam logic [3:0] HLT_OPC_DEFAULT = 4'b1111;

    // The counter must hold the larger of the two initial counts.
    function automatic int cnt_width(input int load_lat, input int drain_cycles);
        int m;
        m = (load_lat > drain_cycles) ? load_lat : drain_cycles;
        if (m < 1) begin
            return 1;
        end
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_ctrl_unit_if : pipeline-side signals of the hazard control unit   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface hazard_ctrl_unit_if #(
    parameter int OPC_W = 4,
    parameter int REG_W = 4
);
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] if_id_rs;
    logic [REG_W-1:0] if_id_rt;
    logic [REG_W-1:0] id_ex_rt;
    logic             id_ex_mr;
    logic             mem_stall;
    logic             branch_taken;
    logic             pc_write;
    logic             if_id_write;
    logic             stall;
    logic             flush;
    logic             halted;

    modport master (
        output opcode, if_id_rs, if_id_rt, id_ex_rt, id_ex_mr, mem_stall, branch_taken,
        input  pc_write, if_id_write, stall, flush, halted
    );

    modport slave (
        input  opcode, if_id_rs, if_id_rt, id_ex_rt, id_ex_mr, mem_stall, branch_taken,
        output pc_write, if_id_write, stall, flush, halted
    );
endinterface
`default_nettype wire

// File: rtl/hazard_cmp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_cmp : load-use register comparator                                |
// | Optional macro HAZARD_ZERO_REG_MASK_EN: ignore loads into register 0.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hazard_cmp #(
    parameter int REG_W = 4
) (
    input  wire logic             i_id_ex_mr,
    input  wire logic [REG_W-1:0] i_id_ex_rt,
    input  wire logic [REG_W-1:0] i_if_id_rs,
    input  wire logic [REG_W-1:0] i_if_id_rt,
    output logic                  o_lu_hit
);
    logic w_match;

    assign w_match = (i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt);

`ifdef HAZARD_ZERO_REG_MASK_EN
    // Register 0 is hardwired, so a load into it never produces a dependency.
    assign o_lu_hit = i_id_ex_mr && w_match && (i_id_ex_rt != '0);
`else
    assign o_lu_hit = i_id_ex_mr && w_match;
`endif

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_ctrl_unit : stateful stall / flush / halt control beside ID stage |
// | Optional macro HAZARD_ZERO_REG_MASK_EN (see hazard_cmp).                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int               OPC_W        = 4,
    parameter int               REG_W        = 4,
    parameter logic [OPC_W-1:0] HLT_OPC      = OPC_W'(HLT_OPC_DEFAULT),
    parameter int               LOAD_LAT     = 1,
    parameter int               DRAIN_CYCLES = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    hazard_ctrl_unit_if.slave bus
);
    localparam int CNT_W = cnt_width(LOAD_LAT, DRAIN_CYCLES);

    localparam logic [1:0] c_st_run      = ST_RUN;
    localparam logic [1:0] c_st_lu_stall = ST_LU_STALL;
    localparam logic [1:0] c_st_drain    = ST_DRAIN;
    localparam logic [1:0] c_st_halted   = ST_HALTED;

    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_lu_init   = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] c_dr_init   = CNT_W'(DRAIN_CYCLES - 1);

    generate
        if (LOAD_LAT < 1 || DRAIN_CYCLES < 1) begin : g_param_check
            $error("hazard_ctrl_unit: LOAD_LAT and DRAIN_CYCLES must be >= 1");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_lu_hit;
    logic             w_hlt_hit;
    logic             w_hazard_stall;
    logic             w_flush;
    logic             w_freeze_any;

    hazard_cmp #(
        .REG_W (REG_W)
    ) u_cmp (
        .i_id_ex_mr (bus.id_ex_mr),
        .i_id_ex_rt (bus.id_ex_rt),
        .i_if_id_rs (bus.if_id_rs),
        .i_if_id_rt (bus.if_id_rt),
        .o_lu_hit   (w_lu_hit)
    );

    assign w_hlt_hit = (bus.opcode == HLT_OPC);

    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        w_hazard_stall = 1'b0;
        w_flush        = 1'b0;

        if (bus.mem_stall) begin
            // Global freeze: everything holds, branch resolution waits in EX.
            w_hazard_stall = 1'b0;
        end else if (bus.branch_taken && (r_state != c_st_halted)) begin
            w_flush      = 1'b1;
            w_next_state = c_st_run;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                c_st_halted: begin
                    w_hazard_stall = 1'b1;
                end
                c_st_drain: begin
                    w_hazard_stall = 1'b1;
                    if (r_cnt == c_cnt_one) begin
                        w_next_state = c_st_halted;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt - c_cnt_one;
                    end
                end
                c_st_lu_stall: begin
                    w_hazard_stall = 1'b1;
                    if (r_cnt == c_cnt_one) begin
                        w_next_state = c_st_run;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    if (w_hlt_hit) begin
                        w_hazard_stall = 1'b1;
                        if (DRAIN_CYCLES == 1) begin
                            w_next_state = c_st_halted;
                            w_next_cnt   = '0;
                        end else begin
                            w_next_state = c_st_drain;
                            w_next_cnt   = c_dr_init;
                        end
                    end else if (w_lu_hit) begin
                        w_hazard_stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_next_state = c_st_lu_stall;
                            w_next_cnt   = c_lu_init;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_run;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // A flush only occurs without mem_stall, so the bubble rides on stall
    // while the PC and IF/ID still advance to the branch target.
    assign w_freeze_any    = bus.mem_stall | w_hazard_stall;
    assign bus.pc_write    = ~w_freeze_any;
    assign bus.if_id_write = ~w_freeze_any;
    assign bus.stall       = w_freeze_any | w_flush;
    assign bus.flush       = w_flush;
    assign bus.halted      = (r_state == c_st_halted);

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hazard_ctrl_unit : scoreboard bench for hazard_ctrl_unit             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_hazard_ctrl_unit;

    // Expected output vector: {pc_write, if_id_write, stall, flush, halted}
    localparam logic [4:0] c_idle  = 5'b11000;
    localparam logic [4:0] c_stall = 5'b00100;
    localparam logic [4:0] c_flush = 5'b11110;
    localparam logic [4:0] c_halt  = 5'b00101;

    typedef struct {
        logic [4:0] exp;
        string      tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    exp_t sb_q[$];

    hazard_ctrl_unit_if #(.OPC_W(4), .REG_W(4)) bus ();

    hazard_ctrl_unit #(
        .OPC_W        (4),
        .REG_W        (4),
        .HLT_OPC      (4'b1111),
        .LOAD_LAT     (3),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic [3:0] opc, input logic [3:0] rs,
                        input logic [3:0] rt, input logic [3:0] ex_rt, input logic mr,
                        input logic ms, input logic br, input logic [4:0] exp,
                        input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n            = rst;
        bus.opcode       = opc;
        bus.if_id_rs     = rs;
        bus.if_id_rt     = rt;
        bus.id_ex_rt     = ex_rt;
        bus.id_ex_mr     = mr;
        bus.mem_stall    = ms;
        bus.branch_taken = br;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic idle(input logic [4:0] exp, input string tag);
        step(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, exp, tag);
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle.
    initial begin
        exp_t       e;
        logic [4:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {bus.pc_write, bus.if_id_write, bus.stall, bus.flush, bus.halted};
                n_total++;
                if (act === e.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got %b expected %b", e.tag, act, e.exp);
                end
            end
        end
    end

    initial begin
        n_pass           = 0;
        n_total          = 0;
        rst_n            = 1'b0;
        bus.opcode       = '0;
        bus.if_id_rs     = 4'h1;
        bus.if_id_rt     = 4'h2;
        bus.id_ex_rt     = 4'h3;
        bus.id_ex_mr     = 1'b0;
        bus.mem_stall    = 1'b0;
        bus.branch_taken = 1'b0;

        step(1'b0, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, c_idle, "reset0");
        step(1'b0, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, c_idle, "reset1");
        idle(c_idle, "idle_after_reset");

        // Load-use: three stall cycles, then back to run.
        step(1'b1, 4'h0, 4'h5, 4'h2, 4'h5, 1'b1, 1'b0, 1'b0, c_stall, "lu_c0");
        idle(c_stall, "lu_c1");
        idle(c_stall, "lu_c2");
        idle(c_idle,  "lu_done");

        // Load-use with a two-cycle mem_stall in the middle: 3+2 stall cycles.
        step(1'b1, 4'h0, 4'h5, 4'h2, 4'h5, 1'b1, 1'b0, 1'b0, c_stall, "lums_c0");
        idle(c_stall, "lums_c1");
        step(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 1'b1, 1'b0, c_stall, "lums_ms0");
        step(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 1'b1, 1'b0, c_stall, "lums_ms1");
        idle(c_stall, "lums_c2");
        idle(c_idle,  "lums_done");

        // mem_stall wins over branch_taken; branch then flushes.
        step(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 1'b1, 1'b1, c_stall, "ms_over_br");
        step(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b1, c_flush, "br_flush");
        idle(c_idle, "br_after");

        // Branch aborts an in-progress load-use stall.
        step(1'b1, 4'h0, 4'h5, 4'h2, 4'h5, 1'b1, 1'b0, 1'b0, c_stall, "lu_abort_c0");
        step(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b1, c_flush, "lu_abort_br");
        idle(c_idle, "lu_abort_after");

        // Wrong-path HLT cancelled in DRAIN; halted never asserts.
        step(1'b1, 4'hF, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, c_stall, "hlt_cancel_c0");
        step(1'b1, 4'hF, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b1, c_flush, "hlt_cancel_br");
        idle(c_idle, "hlt_cancel_a0");
        idle(c_idle, "hlt_cancel_a1");
        idle(c_idle, "hlt_cancel_a2");

        // Load into register 0.
`ifdef HAZARD_ZERO_REG_MASK_EN
        step(1'b1, 4'h0, 4'h3, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, c_idle, "zero_reg_c0");
        idle(c_idle, "zero_reg_c1");
        idle(c_idle, "zero_reg_c2");
`else
        step(1'b1, 4'h0, 4'h3, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, c_stall, "zero_reg_c0");
        idle(c_stall, "zero_reg_c1");
        idle(c_stall, "zero_reg_c2");
`endif
        idle(c_idle, "zero_reg_done");

        // Halt drain: stall for cycles 0-2, halted sticky from cycle 3.
        step(1'b1, 4'hF, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, c_stall, "hlt_c0");
        idle(c_stall, "hlt_c1");
        idle(c_stall, "hlt_c2");
        idle(c_halt,  "hlt_c3");
        idle(c_halt,  "hlt_c4");
        step(1'b1, 4'h0, 4'h5, 4'h2, 4'h5, 1'b1, 1'b0, 1'b1, c_halt, "halted_br");
        step(1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 1'b1, 1'b0, c_halt, "halted_ms");
        step(1'b0, 4'h0, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, c_halt, "halted_rst_cyc");
        idle(c_idle, "post_reset");
        idle(c_idle, "post_reset2");

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        n_total++;
        if (sb_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
